// File: rtl/plot_scheduler.sv
// Round-robin arbiter and rectangle rasteriser for the shared VGA pixel-plot port.
// Four requesters each submit a rectangle; one granted job is written out one pixel per clock.
module plot_scheduler #(
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [39:0] req_x,
  input  logic [39:0] req_y,
  input  logic [23:0] req_w,
  input  logic [23:0] req_h,
  input  logic [11:0] req_color,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [9:0]  plot_x,
  output logic [9:0]  plot_y,
  output logic [2:0]  plot_color,
  output logic        plot_en
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

  localparam logic [10:0] X_LIM = 11'(X_MAX);
  localparam logic [10:0] Y_LIM = 11'(Y_MAX);

  state_t      state, state_n;
  logic [1:0]  rr_ptr, rr_n, sel, sel_n, pick;
  logic [9:0]  x0, x0_n, y0, y0_n;
  logic [5:0]  w, w_n, h, h_n, col, col_n, row, row_n, nc, nr;
  logic [2:0]  color, color_n;
  logic [3:0]  grant_n, ack_n;
  logic        busy_n, pen_n, last_col, last, in_bounds;
  logic [9:0]  px_n, py_n;
  logic [2:0]  pc_n;
  logic [10:0] sx, sy;

  // First requester at or above rr_ptr, wrapping modulo 4
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Next pixel to present; LOAD presents (0,0), DRAW advances in raster order
  assign last_col  = (col == w - 6'd1);
  assign last      = last_col && (row == h - 6'd1);
  assign nc        = (state == DRAW && !last_col) ? col + 6'd1 : 6'd0;
  assign nr        = (state != DRAW) ? 6'd0 : (last_col ? row + 6'd1 : row);
  assign sx        = {1'b0, x0} + {5'b0, nc};
  assign sy        = {1'b0, y0} + {5'b0, nr};
  assign in_bounds = (sx < X_LIM) && (sy < Y_LIM);

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    sel_n   = sel;
    x0_n    = x0;
    y0_n    = y0;
    w_n     = w;
    h_n     = h;
    color_n = color;
    col_n   = col;
    row_n   = row;
    grant_n = '0;
    ack_n   = '0;
    busy_n  = busy;
    px_n    = plot_x;
    py_n    = plot_y;
    pc_n    = plot_color;
    pen_n   = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_n = LOAD;
        sel_n   = pick;
        x0_n    = req_x[10*pick +: 10];
        y0_n    = req_y[10*pick +: 10];
        w_n     = req_w[6*pick +: 6];
        h_n     = req_h[6*pick +: 6];
        color_n = req_color[3*pick +: 3];
        grant_n = 4'b0001 << pick;
        busy_n  = 1'b1;
      end
      LOAD: begin
        col_n = '0;
        row_n = '0;
        if (w == 6'd0 || h == 6'd0) begin
          state_n = DONE;
          ack_n   = 4'b0001 << sel;
        end else begin
          state_n = DRAW;
          px_n    = sx[9:0];
          py_n    = sy[9:0];
          pc_n    = color;
          pen_n   = in_bounds;
        end
      end
      DRAW: if (last) begin
        state_n = DONE;
        ack_n   = 4'b0001 << sel;
      end else begin
        col_n = nc;
        row_n = nr;
        px_n  = sx[9:0];
        py_n  = sy[9:0];
        pen_n = in_bounds;
      end
      DONE: begin
        state_n = IDLE;
        rr_n    = sel + 2'd1;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      sel        <= '0;
      x0         <= '0;
      y0         <= '0;
      w          <= '0;
      h          <= '0;
      color      <= '0;
      col        <= '0;
      row        <= '0;
      grant      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      plot_x     <= '0;
      plot_y     <= '0;
      plot_color <= '0;
      plot_en    <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_n;
      sel        <= sel_n;
      x0         <= x0_n;
      y0         <= y0_n;
      w          <= w_n;
      h          <= h_n;
      color      <= color_n;
      col        <= col_n;
      row        <= row_n;
      grant      <= grant_n;
      ack        <= ack_n;
      busy       <= busy_n;
      plot_x     <= px_n;
      plot_y     <= py_n;
      plot_color <= pc_n;
      plot_en    <= pen_n;
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// Directed and randomized checks of plot_scheduler against a job-level reference model
// (arbitration order, pixel list with clipping, grant/ack timing).
module tb_plot_scheduler;

  logic        clk_50 = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [39:0] req_x = '0, req_y = '0;
  logic [23:0] req_w = '0, req_h = '0;
  logic [11:0] req_color = '0;
  logic [3:0]  grant, ack;
  logic        busy, plot_en;
  logic [9:0]  plot_x, plot_y;
  logic [2:0]  plot_color;

  plot_scheduler dut (
    .clk_50(clk_50), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_color(req_color), .grant(grant), .ack(ack),
    .busy(busy), .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color), .plot_en(plot_en)
  );

  always #10 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int m_rr = 0;
  int ox[4], oy[4], ow[4], oh[4], oc[4];
  int pix_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int pack(input int x, input int y, input int c);
    return x * 65536 + y * 8 + c;
  endfunction

  function automatic int model_pick(input logic [3:0] m, input int rr);
    for (int k = 0; k < 4; k++) if (m[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic apply_ops();
    for (int i = 0; i < 4; i++) begin
      req_x[10*i +: 10]    = 10'(ox[i]);
      req_y[10*i +: 10]    = 10'(oy[i]);
      req_w[6*i +: 6]      = 6'(ow[i]);
      req_h[6*i +: 6]      = 6'(oh[i]);
      req_color[3*i +: 3]  = 3'(oc[i]);
    end
  endtask

  task automatic step();
    @(posedge clk_50);
    #1;
    if (plot_en) pix_q.push_back(pack(int'(plot_x), int'(plot_y), int'(plot_color)));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b1;
    m_rr = 0;
  endtask

  // One job: model picks the winner; others may stay high for 'hold' cycles then withdraw
  task automatic run(input logic [3:0] mask, input int hold, input bit raise);
    int t, win, gc, ac, extra, wx, wy, ww, wh, wc;
    bit got_g, got_a;
    logic [3:0] g, a;
    int exp_q[$];
    pix_q.delete();
    if (raise) begin
      apply_ops();
      req = mask;
    end
    t = cyc;
    win = model_pick(mask, m_rr);
    wx = ox[win]; wy = oy[win]; ww = ow[win]; wh = oh[win]; wc = oc[win];
    for (int r = 0; r < wh; r++)
      for (int c = 0; c < ww; c++)
        if (wx + c < 320 && wy + r < 240) exp_q.push_back(pack(wx + c, wy + r, wc));
    got_g = 0; g = '0; gc = 0;
    for (int k = 0; k < 8 && !got_g; k++) begin
      step();
      if (grant != 0) begin got_g = 1; g = grant; gc = cyc; end
    end
    chk("grant_seen", 32'(got_g), 1);
    if (got_g) begin
      chk("grant_idx", 32'(g), 32'(1 << win));
      chk("grant_cyc", gc, t + 1);
      chk("busy_at_grant", 32'(busy), 1);
      req = req & ~g;
      for (int i = 0; i < 4; i++) begin
        ox[i] = $urandom_range(0, 1023); oy[i] = $urandom_range(0, 1023);
        ow[i] = $urandom_range(0, 63);   oh[i] = $urandom_range(0, 63);
        oc[i] = $urandom_range(0, 7);
      end
      apply_ops();
      got_a = 0; a = '0; ac = 0; extra = 0;
      for (int k = 0; k < 5000 && !got_a; k++) begin
        if (k == hold) req = '0;
        step();
        if (grant != 0) extra++;
        if (ack != 0) begin got_a = 1; a = ack; ac = cyc; end
      end
      req = '0;
      chk("ack_seen", 32'(got_a), 1);
      chk("ack_idx", 32'(a), 32'(1 << win));
      chk("ack_cyc", ac, t + 2 + ww * wh);
      chk("no_extra_grant", extra, 0);
      chk("pixel_count", pix_q.size(), exp_q.size());
      for (int i = 0; i < pix_q.size() && i < exp_q.size(); i++) chk("pixel", pix_q[i], exp_q[i]);
      step();
      chk("idle_after_ack", 32'({busy, plot_en}), 0);
      m_rr = (win + 1) % 4;
    end else req = '0;
  endtask

  initial begin
    int t, n_acks, n_g;
    int gidx[$], gcyc[$];

    // reset state
    step(); step();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_plot_en", 32'(plot_en), 0);
    chk("rst_plot_xyc", 32'({plot_x, plot_y, plot_color}), 0);
    rst = 1'b1;
    step();

    // single job on requester 1
    ox[1] = 10; oy[1] = 20; ow[1] = 2; oh[1] = 3; oc[1] = 5;
    run(4'b0010, 0, 1);

    // four simultaneous 1x1 requests after reset
    do_reset();
    for (int i = 0; i < 4; i++) begin ox[i] = 5 * i; oy[i] = 7; ow[i] = 1; oh[i] = 1; oc[i] = i; end
    apply_ops();
    req = 4'hF;
    t = cyc;
    for (int k = 0; k < 30; k++) begin
      step();
      if (grant != 0) begin
        for (int i = 0; i < 4; i++) if (grant[i]) gidx.push_back(i);
        gcyc.push_back(cyc);
        req = req & ~grant;
      end
    end
    req = '0;
    chk("rr_grant_count", gidx.size(), 4);
    for (int j = 0; j < gidx.size() && j < 4; j++) begin
      chk("rr_order", gidx[j], j);
      chk("rr_spacing", gcyc[j], t + 1 + 4 * j);
    end
    m_rr = 0;
    run(4'b1001, 0, 1);

    // clipping at the bottom-right corner
    ox[2] = 318; oy[2] = 239; ow[2] = 4; oh[2] = 2; oc[2] = 6;
    run(4'b0100, 0, 1);

    // zero-area job
    ox[3] = 40; oy[3] = 40; ow[3] = 0; oh[3] = 5; oc[3] = 1;
    run(4'b1000, 0, 1);

    // reset during the third pixel of a 4x4 job, then a full redraw
    ox[1] = 50; oy[1] = 60; ow[1] = 4; oh[1] = 4; oc[1] = 6;
    apply_ops();
    pix_q.delete();
    n_acks = 0;
    req = 4'b0010;
    for (int k = 0; k < 20 && pix_q.size() < 3; k++) begin
      step();
      if (ack != 0) n_acks++;
    end
    chk("pre_reset_pixels", pix_q.size(), 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant_ack", 32'({grant, ack}), 0);
    chk("mid_rst_busy_en", 32'({busy, plot_en}), 0);
    chk("mid_rst_plot_xyc", 32'({plot_x, plot_y, plot_color}), 0);
    step(); step();
    if (ack != 0) n_acks++;
    chk("no_ack_dropped_job", n_acks, 0);
    rst = 1'b1;
    m_rr = 0;
    run(4'b0010, 0, 0);

    // withdraw of requester 2 mid-draw, operand change after grant
    do_reset();
    ox[0] = 100; oy[0] = 90; ow[0] = 4; oh[0] = 4; oc[0] = 2;
    ox[2] = 200; oy[2] = 10; ow[2] = 3; oh[2] = 3; oc[2] = 7;
    run(4'b0101, 5, 1);
    n_g = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (grant != 0) n_g++;
    end
    chk("withdrawn_never_granted", n_g, 0);

    // randomized jobs with random contention
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 4; i++) begin
        ox[i] = $urandom_range(0, 330); oy[i] = $urandom_range(0, 250);
        ow[i] = $urandom_range(0, 6);   oh[i] = $urandom_range(0, 6);
        oc[i] = $urandom_range(0, 7);
      end
      run(4'($urandom_range(1, 15)), 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
